// File: rtl/tpumac.sv
// Multiply-accumulate cell for one position of the TPU systolic array.
// Define TPUMAC_SATURATE_EN to clamp MAC overflow instead of wrapping.
module tpumac #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      WrEn,
    input  logic signed [BITS_AB-1:0] Ain,
    input  logic signed [BITS_AB-1:0] Bin,
    input  logic signed [BITS_C-1:0]  Cin,
    output logic signed [BITS_AB-1:0] Aout,
    output logic signed [BITS_AB-1:0] Bout,
    output logic signed [BITS_C-1:0]  Cout
);

    // No handshake: every rising edge with en or WrEn high consumes the inputs;
    // results appear on the registered outputs one cycle later.

    localparam int PW = 2 * BITS_AB;

    logic signed [PW-1:0]     prod;
    logic signed [BITS_C-1:0] prod_c;
    logic        [BITS_C-1:0] mac_res;

    logic [BITS_AB-1:0] aout_d, aout_q;
    logic [BITS_AB-1:0] bout_d, bout_q;
    logic [BITS_C-1:0]  cout_d, cout_q;

    assign prod = Ain * Bin;

    generate
        if (BITS_C > PW) begin : g_prod_ext
            assign prod_c = {{(BITS_C - PW){prod[PW-1]}}, prod};
        end else begin : g_prod_trunc
            assign prod_c = prod[BITS_C-1:0];
        end
    endgenerate

`ifdef TPUMAC_SATURATE_EN
    logic [BITS_C:0] sum_w;
    logic            ovf;

    // One guard bit: top two bits differing means the true sum left the range.
    assign sum_w = {Cin[BITS_C-1], Cin} + {prod_c[BITS_C-1], prod_c};
    assign ovf   = sum_w[BITS_C] ^ sum_w[BITS_C-1];

    always_comb begin
        mac_res = sum_w[BITS_C-1:0];
        if (ovf) begin
            if (sum_w[BITS_C]) begin
                mac_res = {1'b1, {(BITS_C - 1){1'b0}}};
            end else begin
                mac_res = {1'b0, {(BITS_C - 1){1'b1}}};
            end
        end
    end
`else
    // Wrapping only needs the low BITS_C bits of the guarded sum.
    assign mac_res = Cin + prod_c;
`endif

    always_comb begin
        aout_d = aout_q;
        bout_d = bout_q;
        cout_d = cout_q;
        if (en) begin
            aout_d = Ain;
            bout_d = Bin;
        end
        if (WrEn) begin
            cout_d = Cin;
        end else if (en) begin
            cout_d = mac_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aout_q <= '0;
            bout_q <= '0;
            cout_q <= '0;
        end else begin
            aout_q <= aout_d;
            bout_q <= bout_d;
            cout_q <= cout_d;
        end
    end

    assign Aout = aout_q;
    assign Bout = bout_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_tpumac.sv
// Directed-vector bench for tpumac; expectations adapt to TPUMAC_SATURATE_EN.
module tb_tpumac;

    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;

`ifdef TPUMAC_SATURATE_EN
    localparam logic [15:0] OVF_POS = 16'h7FFF;
    localparam logic [15:0] OVF_NEG = 16'h8000;
`else
    localparam logic [15:0] OVF_POS = 16'h8000;
    localparam logic [15:0] OVF_NEG = 16'h7FFF;
`endif

    typedef struct {
        logic        rst;
        logic        en;
        logic        wren;
        logic [7:0]  ain;
        logic [7:0]  bin;
        logic [15:0] cin;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic [15:0] exp_c;
    } vec_t;

    logic                      clk;
    logic                      rst;
    logic                      en;
    logic                      wren;
    logic signed [BITS_AB-1:0] ain;
    logic signed [BITS_AB-1:0] bin;
    logic signed [BITS_C-1:0]  cin;
    logic signed [BITS_AB-1:0] aout;
    logic signed [BITS_AB-1:0] bout;
    logic signed [BITS_C-1:0]  cout;

    int   checks;
    int   errors;
    vec_t vecs[$];

    tpumac #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .WrEn (wren),
        .Ain  (ain),
        .Bin  (bin),
        .Cin  (cin),
        .Aout (aout),
        .Bout (bout),
        .Cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent integer model of one MAC step.
    function automatic logic [15:0] mac_model(input int c, input int a, input int b);
        int s;
        s = c + a * b;
`ifdef TPUMAC_SATURATE_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic w,
                       input logic [7:0] a, input logic [7:0] b, input logic [15:0] c,
                       input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] xc);
        vec_t v;
        v.rst = r; v.en = e; v.wren = w; v.ain = a; v.bin = b; v.cin = c;
        v.exp_a = xa; v.exp_b = xb; v.exp_c = xc;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic e, input logic w,
                        input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
        rst = r; en = e; wren = w; ain = a; bin = b; cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] xa,
                             input logic [7:0] xb, input logic [15:0] xc);
        check({tag, ".aout"}, {8'h00, aout}, {8'h00, xa});
        check({tag, ".bout"}, {8'h00, bout}, {8'h00, xb});
        check({tag, ".cout"}, cout, xc);
    endtask

    initial begin
        logic [15:0] acc;
        logic [7:0]  a_v;
        logic [7:0]  b_v;
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; wren = 1'b0; ain = '0; bin = '0; cin = '0;

        //   rst  en   wr   ain    bin    cin        exp_a  exp_b  exp_c
        add(1'b1, 1'b0, 1'b0, 8'h05, 8'h06, 16'h0007, 8'h00, 8'h00, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 8'h09, 8'h0A, 16'h0055, 8'h00, 8'h00, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 16'h0003, 8'h03, 8'h03, 16'h000C);
        add(1'b0, 1'b0, 1'b0, 8'h0A, 8'h0B, 16'h0064, 8'h03, 8'h03, 16'h000C);
        add(1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 16'hFFFB, 8'h80, 8'h80, 16'h3FFB);
        add(1'b0, 1'b1, 1'b0, 8'hF9, 8'h05, 16'h0000, 8'hF9, 8'h05, 16'hFFDD);
        add(1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 16'h1234, 8'hF9, 8'h05, 16'h1234);
        add(1'b0, 1'b1, 1'b1, 8'h02, 8'h02, 16'h0007, 8'h02, 8'h02, 16'h0007);
        add(1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 16'h7FFF, 8'h01, 8'h01, OVF_POS);
        add(1'b0, 1'b1, 1'b0, 8'hFF, 8'h01, 16'h8000, 8'hFF, 8'h01, OVF_NEG);
        add(1'b0, 1'b1, 1'b0, 8'h7F, 8'h7F, 16'h4000, 8'h7F, 8'h7F, 16'h7F01);
        add(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 16'h7FFF, 8'h7F, 8'h7F, 16'h7FFF);
        add(1'b1, 1'b1, 1'b1, 8'h37, 8'h42, 16'h1234, 8'h00, 8'h00, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 16'h5678, 8'h00, 8'h00, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 8'hFE, 8'hFD, 16'hFFF6, 8'hFE, 8'hFD, 16'hFFFC);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].wren, vecs[i].ain, vecs[i].bin, vecs[i].cin);
            check_all($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c);
        end

        // Accumulate with Cout fed back into Cin, as a single-cell column.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
        acc = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            a_v = 8'(i * 37 - 90);
            b_v = 8'(127 - i * 29);
            step(1'b0, 1'b1, 1'b0, a_v, b_v, acc);
            acc = mac_model(int'($signed(acc)), int'($signed(a_v)), int'($signed(b_v)));
            check_all($sformatf("acc%0d", i), a_v, b_v, acc);
        end

        // Reset in the middle of accumulation discards the in-flight value.
        step(1'b1, 1'b1, 1'b0, 8'h40, 8'h40, 16'h0100);
        check_all("midrst", 8'h00, 8'h00, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 8'h40, 8'h40, 16'h0100);
        check_all("postrst", 8'h00, 8'h00, 16'h0000);

        // Preload via WrEn, then one MAC on top of it.
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'hC000);
        check_all("preload", 8'h00, 8'h00, 16'hC000);
        step(1'b0, 1'b1, 1'b0, 8'h80, 8'h7F, 16'hC000);
        check_all("premac", 8'h80, 8'h7F, mac_model(-16384, -128, 127));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpumac.md
Name: tpumac

Overview:
- Single multiply-accumulate cell for the TPU systolic array.
- Each enabled cycle it registers the A and B operands and passes them to its neighbours.
- In the same cycle it registers Cin + Ain*Bin as the partial sum passed down the column.
- A write-enable path loads Cout directly from Cin, for preloading or draining the array.

Parameters:
- BITS_AB, 8: width of the signed A/B operands and the Aout/Bout registers.
- BITS_C, 16: width of the signed Cin and the Cout accumulator register.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  cycle enable for the operand and MAC update.
- WrEn  input  1  load Cout directly from Cin.
- Ain  input  BITS_AB  signed A operand.
- Bin  input  BITS_AB  signed B operand.
- Cin  input  BITS_C  signed partial-sum input.
- Aout  output  BITS_AB  registered Ain, to the next cell east.
- Bout  output  BITS_AB  registered Bin, to the next cell south.
- Cout  output  BITS_C  registered partial sum / accumulator.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset: when rst=1 at a clock edge, Aout, Bout and Cout all become 0. Reset has priority over en and WrEn. Asserting reset mid-operation discards the in-flight value. Outputs are 0 on the first edge after rst deasserts unless en or WrEn is high at that edge.
- Operand pipeline, when en=1: Aout<=Ain and Bout<=Bin. When en=0, Aout and Bout hold.
- C update, in priority order:
  - WrEn=1: Cout<=Cin. This applies regardless of en; Aout/Bout still follow en.
  - else en=1: Cout<=Cin + Ain*Bin.
  - else: Cout holds.
- Latency: one cycle from input to registered output. No combinational path from inputs to outputs.
- Arithmetic:
  - Ain and Bin are two's-complement signed; the product is a full 2*BITS_AB-bit signed result.
  - The product is sign-extended to BITS_C when BITS_C > 2*BITS_AB, else truncated to BITS_C.
  - The sum is formed in BITS_C+1 bits and then reduced to BITS_C bits.
  - Default reduction is a wrap (drop the MSB, modulo 2^BITS_C).
- No handshake: the block consumes inputs on every enabled edge.
- X-free: all registers are defined after the first reset edge.

Optional Feature:
- Macro: TPUMAC_SATURATE_EN.
- When defined, overflow of Cin + Ain*Bin clamps:
  - positive overflow -> 2^(BITS_C-1)-1 (0x7FFF at default width);
  - negative overflow -> -2^(BITS_C-1) (0x8000 at default width).
- Overflow is detected from the BITS_C+1-bit sum when its top two bits differ.
- WrEn loads are never clamped.
- When undefined, results wrap modulo 2^BITS_C.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: rst=1 for one edge with arbitrary inputs -> Aout=0, Bout=0, Cout=0 after the edge. Then rst=0, en=0, WrEn=0 -> all outputs stay 0.
- Basic MAC: en=1, WrEn=0, Ain=3, Bin=3, Cin=3 for one edge -> Aout=3, Bout=3, Cout=12 (0x000C). Then en=0 with new inputs -> all outputs hold.
- Signed MAC: en=1, Ain=-128, Bin=-128, Cin=-5 -> Cout=16379. Then Ain=-7, Bin=5, Cin=0 -> Aout=0xF9, Bout=5, Cout=-35 (0xFFDD).
- WrEn load:
  - en=0, WrEn=1, Cin=0x1234 -> Cout=0x1234; Aout/Bout unchanged.
  - en=1, WrEn=1, Ain=2, Bin=2, Cin=7 -> Cout=7, Aout=2, Bout=2.
- Overflow: en=1, Ain=1, Bin=1, Cin=0x7FFF -> Cout=0x8000 without TPUMAC_SATURATE_EN; Cout=0x7FFF with it.
- Reset priority: rst=1 together with en=1, WrEn=1 and nonzero inputs -> all outputs 0 after the edge.
